timer_irq: RTL
==============

# timer_irq

Memory-mapped interval timer that acts as the interrupt source for the pipelined MIPS core. It sits on the data-memory bus beside data RAM and is selected by address, driven by the same MemRead/MemWrite decode. It raises `irqout`, which the core samples as `IRQ`. The handler runs with `PC_31` set and clears the status bit over the bus, which completes the request/acknowledge loop.

## Interface
Parameters:
- `BASE`, default 32'h4000_0000: base address of the register block.
- `TH_RST`, default 32'h0000_0000: reset value of the reload register.

Ports:
- `clk`, input, 1: system clock, all state on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rd`, input, 1: bus read strobe (MemRead).
- `wr`, input, 1: bus write strobe (MemWrite).
- `addr`, input, 32: byte address. Word aligned; `addr[1:0]` is ignored.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data.
- `irqout`, output, 1: level interrupt request to the core.

## Operation
Register map, offsets from `BASE`:
- 0x00 `TH`, R/W: reload value.
- 0x04 `TL`, R/W: counter.
- 0x08 `TCON`, R/W:
  - bit0 `EN`: counter enable.
  - bit1 `IE`: interrupt enable.
  - bit2 `IS`: interrupt status. Cleared only by writing 0 to it.
  - bits 31:3 read as 0.
- 0x0C `PRESC`, R/W: present only with the configuration macro (see Configuration).
- 0x14 `SYSTICK`, read-only: free-running 32-bit cycle count. Writes are ignored.

Address handling:
- An access hits when `addr[31:5] == BASE[31:5]` and the offset is a listed register.
- An unmapped hit, or any access with no hit: reads return 0, writes have no effect.

Counting:
- Each tick with `EN=1`: if `TL == 32'hFFFF_FFFF`, then `TL <= TH`, and `IS <= 1` when `IE=1`. Otherwise `TL <= TL + 1` (unsigned, 32-bit).
- Without the macro, a tick is every cycle.
- `SYSTICK` increments every cycle regardless of `EN` and wraps from 32'hFFFF_FFFF to 0.

Interrupt output:
- `irqout = IE & IS`, combinational from the registers.
- The block does not look at `PC_31`; masking during the handler is the core's job.

Priority when events coincide in one cycle:
- Bus write to `TL` vs. counting/reload: the bus write wins.
- Bus write to `TH` at the same time as a reload: the reload uses the old `TH`.
- Bus write of `IS=0` at the same time as an overflow with `IE=1`: the hardware set wins and `IS` stays 1, so no interrupt is lost.
- A `TCON` write updates `EN` and `IE` in the same edge. An overflow in that cycle uses the old `EN` and `IE`.
- `rd` and `wr` both high: the write occurs, and `rdata` shows the pre-write value.

## Timing
- Reset values:
  - `TH = TH_RST`.
  - `TL`, `TCON`, `SYSTICK` (and `PRESC` and its counter when configured) = 0.
  - `irqout = 0`, `rdata = 0`.
- `reset` asserted mid-count overrides every bus access and tick in that cycle.
- Reads:
  - `rdata` is combinational in the same cycle as `rd`.
  - It is 0 whenever `rd = 0`.
  - It reflects register state before the current edge.
- Writes take effect at the rising edge where `wr = 1`.
- Interrupt latency: `irqout` rises in the cycle after the edge on which `TL` wrapped.
- Clearing `IS` by bus write drops `irqout` the cycle after the write edge.
- Interrupt period with `EN = IE = 1`: (2^32 − `TH`) ticks.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - Adds the `PRESC` register (16 bits, upper bits read 0) and a 16-bit prescale counter.
  - A tick occurs when the prescale counter equals `PRESC`; the counter then returns to 0, otherwise it increments.
  - The prescale counter resets to 0 on any `TCON` write.
  - `PRESC = 0` gives a tick every cycle.
- `TIMER_PRESCALE_EN` undefined:
  - Tick every cycle.
  - Offset 0x0C is unmapped.

## Structure
- Package `timer_pkg` holds:
  - Register offsets (`TH_OFS`, `TL_OFS`, `TCON_OFS`, `PRESC_OFS`, `SYSTICK_OFS`).
  - `TCON` bit indices (`TCON_EN`, `TCON_IE`, `TCON_IS`).
- One sub-module, `timer_prescaler`:
  - Ports: clk, reset, clear, limit, tick.
  - Instantiated only under `TIMER_PRESCALE_EN`; otherwise tick is tied to 1.

## Test plan
- Reset, then read all registers: `TH = TH_RST`, `TL = TCON = SYSTICK = 0`, `irqout = 0`.
- Reload and interrupt:
  - Stimulus: write `TH = FFFF_FFFC`, `TL = FFFF_FFFC`, `TCON = 3`.
  - `TL` reads FFFF_FFFD, FFFF_FFFE, FFFF_FFFF, then FFFF_FFFC.
  - `irqout` goes to 1 the cycle after the wrap and stays at 1.
- Acknowledge:
  - With `IS = 1`, write `TCON = 3`: `irqout` falls next cycle.
  - Repeat so the clear coincides with the next wrap: `IS` stays 1.
- Enable gating: with `IE = 0` and `EN = 1`, a wrap reloads `TL` but `IS` and `irqout` stay 0. With `EN = 0`, `TL` holds its value for 10 cycles.
- Write priority:
  - Write `TL = 5` on the wrap cycle: `TL` reads 5.
  - Write `TH = 7` on the wrap cycle: `TL` reloads the old `TH`.
- With `TIMER_PRESCALE_EN`: `PRESC = 3`, `TL = 0`, `TCON = 1`. After 12 cycles `TL = 3`. An unmapped address 0x4000_0010 reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer.
// Holds the register offsets, the TCON bit positions and the TCON layout.
package timer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OFS_W   = 5;
  localparam int unsigned PRESC_W = 16;

  localparam logic [OFS_W-1:0] TH_OFS      = 5'h00;
  localparam logic [OFS_W-1:0] TL_OFS      = 5'h04;
  localparam logic [OFS_W-1:0] TCON_OFS    = 5'h08;
  localparam logic [OFS_W-1:0] PRESC_OFS   = 5'h0C;
  localparam logic [OFS_W-1:0] SYSTICK_OFS = 5'h14;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  // Packed so that bit positions line up with TCON_EN/IE/IS.
  typedef struct packed {
    logic is_;
    logic ie;
    logic en;
  } tcon_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: tick pulses when the counter equals limit, then restarts.
// Ports: clk, reset (sync, active-high), clear (restart count),
//        limit (tick period minus one), tick (combinational pulse).
module timer_prescaler
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [PRESC_W-1:0] limit,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == limit);

  // Count up, wrapping to 0 on a tick or an explicit restart.
  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer and interrupt source on the data-memory bus.
// Ports: clk, reset (sync, active-high), rd/wr bus strobes, addr (byte,
//        word aligned), wdata, rdata (combinational, 0 when rd=0),
//        irqout (IE & IS level request).
// Optional: define TIMER_PRESCALE_EN to add the PRESC register and prescaler;
//           otherwise the counter ticks every cycle and offset 0x0C is unmapped.
module timer_irq
  import timer_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE   = 32'h4000_0000,
  parameter logic [DATA_W-1:0] TH_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irqout
);

  logic [DATA_W-1:0] th_q, th_d, tl_q, tl_d, sys_q, sys_d;
  tcon_t             tcon_q, tcon_d;
  logic              hit, tick, wrap;
  logic [OFS_W-1:0]  ofs;
  logic              we_th, we_tl, we_tcon;
  logic              unused_addr;

  // Address decode: the low two byte-address bits are don't-care.
  assign hit         = (addr[DATA_W-1:OFS_W] == BASE[DATA_W-1:OFS_W]);
  assign ofs         = {addr[OFS_W-1:2], 2'b00};
  assign unused_addr = ^addr[1:0];
  assign we_th       = wr && hit && (ofs == TH_OFS);
  assign we_tl       = wr && hit && (ofs == TL_OFS);
  assign we_tcon     = wr && hit && (ofs == TCON_OFS);

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               we_presc;

  assign we_presc = wr && hit && (ofs == PRESC_OFS);

  timer_prescaler u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (we_tcon),
    .limit (presc_q),
    .tick  (tick)
  );

  always_comb begin
    presc_d = presc_q;
    if (we_presc) presc_d = wdata[PRESC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // Wrap decision uses the pre-edge EN so a same-cycle TCON write cannot affect it.
  assign wrap = tick && tcon_q.en && (tl_q == '1);

  // Next state: counting first, then bus writes override; a wrap with the old
  // IE re-asserts IS last so a coinciding clear never loses an interrupt.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    sys_d  = sys_q + DATA_W'(1);
    if (tick && tcon_q.en) tl_d = wrap ? th_q : tl_q + DATA_W'(1);
    if (we_tl) tl_d = wdata;
    if (we_th) th_d = wdata;
    if (we_tcon) begin
      tcon_d.en  = wdata[TCON_EN];
      tcon_d.ie  = wdata[TCON_IE];
      tcon_d.is_ = tcon_q.is_ & wdata[TCON_IS];
    end
    if (wrap && tcon_q.ie) tcon_d.is_ = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= TH_RST;
      tl_q   <= '0;
      tcon_q <= '0;
      sys_q  <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      sys_q  <= sys_d;
    end
  end

  // Read mux reflects pre-edge register state.
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (ofs)
        TH_OFS:      rdata = th_q;
        TL_OFS:      rdata = tl_q;
        TCON_OFS:    rdata = DATA_W'(tcon_q);
`ifdef TIMER_PRESCALE_EN
        PRESC_OFS:   rdata = DATA_W'(presc_q);
`else
        PRESC_OFS:   rdata = '0;
`endif
        SYSTICK_OFS: rdata = sys_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign irqout = tcon_q.ie & tcon_q.is_;

endmodule
